if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_pkg.sv | 13 +
 rtl/if_pc_sel.sv | 24 ++
 rtl/if_stage.sv | 123 ++++++++++++
 tb/tb_if_stage.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and reset/nop constants.
package if_stage_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MISS    = 2'd1,
    MISS_RD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pc_sel.sv
// Redirect detection and target priority select (jr/jalr beats j/jal beats branch).
module if_pc_sel (
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic        redir,
  output logic [31:0] target
);

  assign redir = PCSrc | Jump | JumpR;

  always_comb begin
    target = br_target;
    if (JumpR) begin
      target = jr_target;
    end else if (Jump) begin
      target = j_target;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: pc register, I-cache request, miss/redirect FSM and IF/ID register.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  output logic        ICACHE_ren,
  output logic [29:0] ICACHE_addr,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall,
  input  logic        stall_id,
  input  logic        PCSrc,
  input  logic        Jump,
  input  logic        JumpR,
  input  logic [31:0] br_target,
  input  logic [31:0] j_target,
  input  logic [31:0] jr_target,
  output logic [31:0] IFID_pc4,
  output logic [31:0] IFID_inst,
  output logic        IFID_valid,
  output logic [31:0] pc
);

  import if_stage_pkg::*;

  fetch_state_t state, state_n;
  logic [31:0]  pending, pending_n;
  logic [31:0]  pc_n, pc_plus4;
  logic [31:0]  pc4_n, inst_n;
  logic         valid_n;
  logic         redir, take_redir, bubble;
  logic [31:0]  target;

  if_pc_sel u_pc_sel (
    .PCSrc     (PCSrc),
    .Jump      (Jump),
    .JumpR     (JumpR),
    .br_target (br_target),
    .j_target  (j_target),
    .jr_target (jr_target),
    .redir     (redir),
    .target    (target)
  );

  assign pc_plus4    = pc + 32'd4;
  assign ICACHE_ren  = ~rst;
  assign ICACHE_addr = pc[31:2];
  // A load-use hazard means branch operands may be stale, so redirects are masked.
  assign take_redir  = redir & ~stall_id;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    pc_n      = pc;
    pc4_n     = IFID_pc4;
    inst_n    = IFID_inst;
    valid_n   = IFID_valid;
    bubble    = 1'b0;
    case (state)
      RUN, MISS: begin
        if (ICACHE_stall) begin
          bubble = ~stall_id;
          if (take_redir) begin
            state_n   = MISS_RD;
            pending_n = target;
          end else begin
            state_n = MISS;
          end
        end else begin
          state_n = RUN;
          if (!stall_id) begin
            if (redir) begin
              pc_n   = target;
              bubble = 1'b1;
            end else begin
              pc_n    = pc_plus4;
              pc4_n   = pc_plus4;
              inst_n  = ICACHE_rdata;
              valid_n = 1'b1;
            end
          end
        end
      end
      MISS_RD: begin
        bubble = ~stall_id;
        if (take_redir) begin
          pending_n = target;
        end
        // The returned word belongs to the abandoned path; jump to the newest target instead.
        if (!ICACHE_stall) begin
          pc_n    = take_redir ? target : pending;
          state_n = RUN;
        end
      end
      default: begin
        state_n = RUN;
      end
    endcase
    if (bubble) begin
      pc4_n   = 32'd0;
      inst_n  = NOP_INST;
      valid_n = 1'b0;
    end
  end

  // IF/ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      pending    <= 32'd0;
      pc         <= RESET_PC;
      IFID_pc4   <= 32'd0;
      IFID_inst  <= NOP_INST;
      IFID_valid <= 1'b0;
    end else begin
      state      <= state_n;
      pending    <= pending_n;
      pc         <= pc_n;
      IFID_pc4   <= pc4_n;
      IFID_inst  <= inst_n;
      IFID_valid <= valid_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic against a pending-redirect reference model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ICACHE_ren;
  logic [29:0] ICACHE_addr;
  logic [31:0] ICACHE_rdata;
  logic        ICACHE_stall;
  logic        stall_id;
  logic        PCSrc, Jump, JumpR;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] IFID_pc4, IFID_inst, pc;
  logic        IFID_valid;

  int total = 0;
  int bad   = 0;

  // Reference model state: a redirect remembered during a miss is just a flag plus an address.
  logic [31:0] m_pc, m_pc4, m_inst, m_pend;
  logic        m_valid, m_pend_v;

  always #5 clk = ~clk;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ICACHE_ren   (ICACHE_ren),
    .ICACHE_addr  (ICACHE_addr),
    .ICACHE_rdata (ICACHE_rdata),
    .ICACHE_stall (ICACHE_stall),
    .stall_id     (stall_id),
    .PCSrc        (PCSrc),
    .Jump         (Jump),
    .JumpR        (JumpR),
    .br_target    (br_target),
    .j_target     (j_target),
    .jr_target    (jr_target),
    .IFID_pc4     (IFID_pc4),
    .IFID_inst    (IFID_inst),
    .IFID_valid   (IFID_valid),
    .pc           (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic model_bubble();
    m_pc4   = 32'd0;
    m_inst  = 32'd0;
    m_valid = 1'b0;
  endtask

  task automatic model_step();
    logic        want;
    logic        take;
    logic [31:0] tgt;
    if (rst) begin
      m_pc = 0; m_pend = 0; m_pend_v = 0;
      model_bubble();
    end else begin
      want = PCSrc || Jump || JumpR;
      tgt  = JumpR ? jr_target : (Jump ? j_target : br_target);
      take = want && !stall_id;
      if (ICACHE_stall) begin
        if (!stall_id) model_bubble();
        if (take) begin
          m_pend_v = 1'b1;
          m_pend   = tgt;
        end
      end else if (m_pend_v) begin
        m_pc     = take ? tgt : m_pend;
        m_pend_v = 1'b0;
        if (!stall_id) model_bubble();
      end else if (!stall_id) begin
        if (want) begin
          m_pc = tgt;
          model_bubble();
        end else begin
          m_pc    = m_pc + 32'd4;
          m_pc4   = m_pc;
          m_inst  = ICACHE_rdata;
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [31:0] a;
    @(posedge clk);
    model_step();
    #1;
    chk("pc", pc, m_pc);
    chk("ifid_pc4", IFID_pc4, m_pc4);
    chk("ifid_inst", IFID_inst, m_inst);
    chk("ifid_valid", {31'd0, IFID_valid}, {31'd0, m_valid});
    a = m_pc >> 2;
    chk("icache_addr", {2'b00, ICACHE_addr}, a);
    chk("icache_ren", {31'd0, ICACHE_ren}, {31'd0, ~rst});
    @(negedge clk);
  endtask

  task automatic idle();
    ICACHE_stall = 0; stall_id = 0;
    PCSrc = 0; Jump = 0; JumpR = 0;
    br_target = 0; j_target = 0; jr_target = 0;
    ICACHE_rdata = $urandom();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_pc = 0; m_pc4 = 0; m_inst = 0; m_valid = 0; m_pend = 0; m_pend_v = 0;
    @(negedge clk);
    cycle();
    cycle();
    chk("reset_pc", pc, 32'h0);
    chk("reset_valid", {31'd0, IFID_valid}, 32'd0);

    // sequential fetch on hits
    rst = 1'b0;
    idle(); cycle();
    chk("seq_pc4_1", IFID_pc4, 32'd4);
    chk("seq_valid_1", {31'd0, IFID_valid}, 32'd1);
    idle(); cycle();
    chk("seq_pc4_2", IFID_pc4, 32'd8);
    idle(); cycle();
    chk("seq_pc4_3", IFID_pc4, 32'd12);

    // simultaneous redirect: jr wins over branch
    idle(); Jump = 1; j_target = 32'h40; cycle();
    chk("goto_40", pc, 32'h40);
    idle(); JumpR = 1; jr_target = 32'h100; PCSrc = 1; br_target = 32'h80; cycle();
    chk("prio_pc", pc, 32'h100);
    chk("prio_valid", {31'd0, IFID_valid}, 32'd0);

    // redirect during a 5-cycle miss
    for (int i = 0; i < 5; i++) begin
      idle(); ICACHE_stall = 1;
      if (i == 1) begin Jump = 1; j_target = 32'h200; end
      cycle();
      chk("miss_pc_hold", pc, 32'h100);
    end
    idle(); cycle();
    chk("miss_redir_pc", pc, 32'h200);
    chk("miss_redir_valid", {31'd0, IFID_valid}, 32'd0);

    // hazard masks the branch and freezes IF/ID
    idle(); Jump = 1; j_target = 32'h1C; cycle();
    idle(); ICACHE_rdata = 32'hDEADBEEF; cycle();
    chk("pre_haz_pc", pc, 32'h20);
    idle(); stall_id = 1; PCSrc = 1; br_target = 32'h80; cycle();
    chk("haz_pc", pc, 32'h20);
    chk("haz_pc4", IFID_pc4, 32'h20);
    chk("haz_inst", IFID_inst, 32'hDEADBEEF);
    chk("haz_valid", {31'd0, IFID_valid}, 32'd1);

    // pc wrap, then reset while a redirected miss is outstanding
    idle(); Jump = 1; j_target = 32'hFFFF_FFFC; cycle();
    idle(); cycle();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", IFID_pc4, 32'h0);
    idle(); ICACHE_stall = 1; Jump = 1; j_target = 32'h300; cycle();
    idle(); ICACHE_stall = 1; cycle();
    idle(); ICACHE_stall = 1; rst = 1; cycle();
    chk("rst_missrd_pc", pc, 32'h0);
    rst = 0; idle(); cycle();
    chk("post_rst_pc", pc, 32'h4);
    chk("post_rst_valid", {31'd0, IFID_valid}, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      rst          = ($urandom_range(0, 99) < 2);
      ICACHE_stall = ($urandom_range(0, 99) < 30);
      stall_id     = ($urandom_range(0, 99) < 20);
      PCSrc        = ($urandom_range(0, 99) < 15);
      Jump         = ($urandom_range(0, 99) < 10);
      JumpR        = ($urandom_range(0, 99) < 10);
      br_target    = $urandom() & 32'hFFFF_FFFC;
      j_target     = $urandom() & 32'hFFFF_FFFC;
      jr_target    = $urandom() & 32'hFFFF_FFFC;
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
